// File: rtl/pll_phase_lock_detect_if.sv
// Signal bundle between the feedback-side phase/lock detector and its surroundings.
// The detector takes the slave side; the driver of ref/fb/m takes the master side.
interface pll_phase_lock_detect_if #(
    parameter int CNT_W = 10
);
    logic                    ref_in;
    logic                    fb_in;
    logic [CNT_W-1:0]        m;
    logic                    up;
    logic                    dn;
    logic signed [CNT_W:0]   phase_err;
    logic                    err_valid;
    logic [CNT_W-1:0]        fb_period;
    logic                    period_ok;
    logic                    lock;

    modport master (
        output ref_in, fb_in, m,
        input  up, dn, phase_err, err_valid, fb_period, period_ok, lock
    );

    modport slave (
        input  ref_in, fb_in, m,
        output up, dn, phase_err, err_valid, fb_period, period_ok, lock
    );
endinterface

// File: rtl/pll_phase_lock_detect.sv
// Digital PFD and lock detector for the divided VCO feedback, clocked by vco.
// Oversamples ref/fb, reports signed phase error, measures the fb period and qualifies lock.
module pll_phase_lock_detect #(
    parameter int SYNC_STAGES = 2,
    parameter int CNT_W       = 10,
    parameter int ERR_TOL     = 2,
    parameter int LOCK_COUNT  = 16
) (
    input  logic                    vco,
    input  logic                    rst,
    pll_phase_lock_detect_if.slave  bus
);

    localparam logic [CNT_W-1:0] CNT_MAX  = '1;
    localparam logic [CNT_W-1:0] CNT_ONE  = CNT_W'(1);
    localparam logic [CNT_W-1:0] M_MIN    = CNT_W'(2);
    localparam logic [CNT_W:0]   TOL      = (CNT_W + 1)'(ERR_TOL);
    localparam int               LCW      = $clog2(LOCK_COUNT + 1);
    localparam logic [LCW-1:0]   LOCK_MAX = LCW'(LOCK_COUNT);
    localparam logic [LCW-1:0]   LOCK_ONE = LCW'(1);

    // ------------------------------------------------------------------
    // Input path: synchronizer chain plus registered rising-edge pulse.
    // Index 0 is the reference, index 1 the feedback.
    // ------------------------------------------------------------------
    logic [1:0] raw_in;
    logic [1:0] rise_pulse;
    logic       ref_rise;
    logic       fb_rise;

    assign raw_in = {bus.fb_in, bus.ref_in};

    for (genvar gi = 0; gi < 2; gi++) begin : g_sync
        logic [SYNC_STAGES-1:0] sync_reg;
        logic                   last_reg;
        logic                   rise_reg;

        always_ff @(posedge vco) begin
            if (rst) begin
                sync_reg <= '0;
                last_reg <= 1'b0;
                rise_reg <= 1'b0;
            end else begin
                sync_reg <= {sync_reg[SYNC_STAGES-2:0], raw_in[gi]};
                last_reg <= sync_reg[SYNC_STAGES-1];
                rise_reg <= sync_reg[SYNC_STAGES-1] & ~last_reg;
            end
        end

        assign rise_pulse[gi] = rise_reg;
    end

    assign ref_rise = rise_pulse[0];
    assign fb_rise  = rise_pulse[1];

    // ------------------------------------------------------------------
    // PFD state machine
    // ------------------------------------------------------------------
    typedef enum logic [1:0] {
        ST_IDLE,
        ST_UP,
        ST_DN
    } pfd_state_t;

    pfd_state_t            state_reg;
    logic [CNT_W-1:0]      pcnt_reg;
    logic [CNT_W-1:0]      pcnt_next;
    logic signed [CNT_W:0] pcnt_pos;
    logic signed [CNT_W:0] pcnt_neg;
    logic signed [CNT_W:0] phase_err_reg;
    logic                  err_valid_reg;
    logic                  up_reg;
    logic                  dn_reg;

    // Saturating count: a stalled edge must never fold back into a small error.
    assign pcnt_next = (pcnt_reg == CNT_MAX) ? CNT_MAX : pcnt_reg + CNT_ONE;
    assign pcnt_pos  = $signed({1'b0, pcnt_reg});
    assign pcnt_neg  = -pcnt_pos;

    always_ff @(posedge vco) begin
        if (rst) begin
            state_reg     <= ST_IDLE;
            pcnt_reg      <= '0;
            phase_err_reg <= '0;
            err_valid_reg <= 1'b0;
            up_reg        <= 1'b0;
            dn_reg        <= 1'b0;
        end else begin
            err_valid_reg <= 1'b0;
            case (state_reg)
                ST_IDLE: begin
                    if (ref_rise && fb_rise) begin
                        phase_err_reg <= '0;
                        err_valid_reg <= 1'b1;
                    end else if (ref_rise) begin
                        state_reg <= ST_UP;
                        up_reg    <= 1'b1;
                        pcnt_reg  <= CNT_ONE;
                    end else if (fb_rise) begin
                        state_reg <= ST_DN;
                        dn_reg    <= 1'b1;
                        pcnt_reg  <= CNT_ONE;
                    end
                end
                ST_UP: begin
                    if (fb_rise) begin
                        phase_err_reg <= pcnt_pos;
                        err_valid_reg <= 1'b1;
                        if (ref_rise) begin
                            pcnt_reg <= CNT_ONE;
                        end else begin
                            state_reg <= ST_IDLE;
                            up_reg    <= 1'b0;
                        end
                    end else begin
                        // A second ref edge keeps counting: frequency-detect behaviour.
                        pcnt_reg <= pcnt_next;
                    end
                end
                ST_DN: begin
                    if (ref_rise) begin
                        phase_err_reg <= pcnt_neg;
                        err_valid_reg <= 1'b1;
                        if (fb_rise) begin
                            pcnt_reg <= CNT_ONE;
                        end else begin
                            state_reg <= ST_IDLE;
                            dn_reg    <= 1'b0;
                        end
                    end else begin
                        pcnt_reg <= pcnt_next;
                    end
                end
                default: begin
                    state_reg <= ST_IDLE;
                    up_reg    <= 1'b0;
                    dn_reg    <= 1'b0;
                end
            endcase
        end
    end

    // ------------------------------------------------------------------
    // Feedback period measurement
    // ------------------------------------------------------------------
    logic [CNT_W-1:0] pdcnt_reg;
    logic             armed_reg;
    logic [CNT_W-1:0] fb_period_reg;
    logic             period_ok_reg;
    logic             period_bad_reg;
    logic             ratio_match;

    // m below 2 means the divider is bypassed, so no ratio can be confirmed.
    assign ratio_match = (pdcnt_reg == bus.m) && (bus.m >= M_MIN);

    always_ff @(posedge vco) begin
        if (rst) begin
            pdcnt_reg      <= '0;
            armed_reg      <= 1'b0;
            fb_period_reg  <= '0;
            period_ok_reg  <= 1'b0;
            period_bad_reg <= 1'b0;
        end else begin
            period_bad_reg <= 1'b0;
            if (fb_rise) begin
                pdcnt_reg <= CNT_ONE;
                armed_reg <= 1'b1;
                if (armed_reg) begin
                    fb_period_reg  <= pdcnt_reg;
                    period_ok_reg  <= ratio_match;
                    period_bad_reg <= ~ratio_match;
                end
            end else if (pdcnt_reg != CNT_MAX) begin
                pdcnt_reg <= pdcnt_reg + CNT_ONE;
            end else begin
                period_ok_reg  <= 1'b0;
                period_bad_reg <= 1'b1;
            end
        end
    end

    // ------------------------------------------------------------------
    // Lock qualification
    // ------------------------------------------------------------------
    logic [CNT_W:0] phase_mag;
    logic           cmp_good;
    logic [LCW-1:0] lock_cnt_reg;
    logic           lock_reg;

    assign phase_mag = phase_err_reg[CNT_W] ? $unsigned(-phase_err_reg)
                                            : $unsigned(phase_err_reg);
    assign cmp_good  = (phase_mag <= TOL) && period_ok_reg;

    // A bad or stalled period outranks a simultaneous good phase comparison.
    always_ff @(posedge vco) begin
        if (rst) begin
            lock_cnt_reg <= '0;
            lock_reg     <= 1'b0;
        end else if (period_bad_reg) begin
            lock_cnt_reg <= '0;
            lock_reg     <= 1'b0;
        end else if (err_valid_reg) begin
            if (cmp_good) begin
                if (lock_cnt_reg != LOCK_MAX) begin
                    lock_cnt_reg <= lock_cnt_reg + LOCK_ONE;
                end
                lock_reg <= (lock_cnt_reg >= LOCK_MAX - LOCK_ONE);
            end else begin
                lock_cnt_reg <= '0;
                lock_reg     <= 1'b0;
            end
        end
    end

    assign bus.up        = up_reg;
    assign bus.dn        = dn_reg;
    assign bus.phase_err = phase_err_reg;
    assign bus.err_valid = err_valid_reg;
    assign bus.fb_period = fb_period_reg;
    assign bus.period_ok = period_ok_reg;
    assign bus.lock      = lock_reg;

endmodule

// File: tb/tb_pll_phase_lock_detect.sv
// Directed bench for pll_phase_lock_detect: vco-synchronous ref/fb square waves with
// hand-computed phase error, period, PFD pulse width and lock expectations.
module tb_pll_phase_lock_detect;

    localparam int CNT_W = 10;

    logic vco = 1'b0;
    logic rst = 1'b1;

    pll_phase_lock_detect_if #(.CNT_W(CNT_W)) bus ();

    pll_phase_lock_detect #(
        .SYNC_STAGES (2),
        .CNT_W       (CNT_W),
        .ERR_TOL     (2),
        .LOCK_COUNT  (16)
    ) dut (
        .vco (vco),
        .rst (rst),
        .bus (bus)
    );

    always #5 vco = ~vco;

    int n_vec  = 0;
    int n_miss = 0;
    int cyc    = 0;
    int per    = 8;
    int ref_off = 0;
    int fb_off  = 0;
    bit ref_en  = 1'b0;
    bit fb_en   = 1'b0;

    task automatic check_val(input string tag, input int got, input int exp);
        n_vec++;
        if (got != exp) begin
            n_miss++;
            $display("FAIL %s: got %0d, expected %0d", tag, got, exp);
        end
    endtask

    function automatic bit wave(input int c, input int off);
        if (c < off) return 1'b0;
        return ((c - off) % per) < (per / 2);
    endfunction

    // Drive inputs just after a falling edge, sample outputs at the next falling edge.
    task automatic tick();
        bus.ref_in = ref_en && wave(cyc, ref_off);
        bus.fb_in  = fb_en && wave(cyc, fb_off);
        @(posedge vco);
        @(negedge vco);
        cyc++;
    endtask

    task automatic do_reset();
        rst    = 1'b1;
        ref_en = 1'b0;
        fb_en  = 1'b0;
        tick();
        tick();
        rst    = 1'b0;
        cyc    = 0;
        ref_en = 1'b1;
        fb_en  = 1'b1;
    endtask

    task automatic wait_ev(input string tag, input int limit);
        int i;
        i = 0;
        do begin
            tick();
            i++;
        end while (!bus.err_valid && i < limit);
        if (!bus.err_valid) check_val(tag, 0, 1);
        else $display("ev %s: phase_err=%0d fb_period=%0d period_ok=%0d lock=%0d",
                      tag, $signed(bus.phase_err), bus.fb_period, bus.period_ok, bus.lock);
    endtask

    // Runs n cycles; at every err_valid checks phase error, PFD pulse width since the
    // previous comparison and the period result, then checks lock one cycle later.
    // The first comparison after reset only arms the period measurement.
    task automatic run(input int n, input int exp_err, input int exp_up, input int exp_dn,
                       input int exp_period, input int exp_ok, input int good_from);
        int  up_cnt;
        int  dn_cnt;
        int  ev;
        int  lock_exp;
        bit  lock_due;
        up_cnt = 0; dn_cnt = 0; ev = 0; lock_exp = 0; lock_due = 1'b0;
        for (int i = 0; i < n; i++) begin
            tick();
            if (lock_due) begin
                check_val("lock_after_ev", bus.lock, lock_exp);
                lock_due = 1'b0;
            end
            if (bus.up) up_cnt++;
            if (bus.dn) dn_cnt++;
            if (bus.err_valid) begin
                ev++;
                $display("ev %0d: phase_err=%0d fb_period=%0d period_ok=%0d up_cyc=%0d dn_cyc=%0d lock=%0d",
                         ev, $signed(bus.phase_err), bus.fb_period, bus.period_ok,
                         up_cnt, dn_cnt, bus.lock);
                check_val("phase_err", $signed(bus.phase_err), exp_err);
                check_val("up_cycles", up_cnt, exp_up);
                check_val("dn_cycles", dn_cnt, exp_dn);
                if (ev == 1) begin
                    check_val("fb_period_arm", bus.fb_period, 0);
                    check_val("period_ok_arm", bus.period_ok, 0);
                end else begin
                    check_val("fb_period", bus.fb_period, exp_period);
                    check_val("period_ok", bus.period_ok, exp_ok);
                end
                lock_exp = (good_from > 0 && ev - good_from + 1 >= 16) ? 1 : 0;
                lock_due = 1'b1;
                up_cnt = 0;
                dn_cnt = 0;
            end
        end
    endtask

    task automatic check_idle_outputs(input string tag);
        check_val({tag, "_up"},        bus.up, 0);
        check_val({tag, "_dn"},        bus.dn, 0);
        check_val({tag, "_phase_err"}, $signed(bus.phase_err), 0);
        check_val({tag, "_err_valid"}, bus.err_valid, 0);
        check_val({tag, "_lock"},      bus.lock, 0);
    endtask

    task automatic lock_in_phase(input int m_val, input int p);
        bus.m = CNT_W'(m_val);
        per = p; ref_off = 0; fb_off = 0;
        do_reset();
        run(20 * p, 0, 0, 0, p, 1, 2);
    endtask

    int hold_ev;

    initial begin
        bus.ref_in = 1'b0;
        bus.fb_in  = 1'b0;
        bus.m      = CNT_W'(8);

        // 1: in phase at m=8; lock after 16 good comparisons (the arming one is not good)
        do_reset();
        check_idle_outputs("reset");
        check_val("reset_fb_period", bus.fb_period, 0);
        check_val("reset_period_ok", bus.period_ok, 0);
        per = 8; ref_off = 0; fb_off = 0;
        run(160, 0, 0, 0, 8, 1, 2);
        check_val("t1_lock_final", bus.lock, 1);

        // 2: ref leads fb by 3 -> +3, up 3 cycles, never locks
        ref_off = 0; fb_off = 3;
        do_reset();
        run(160, 3, 3, 0, 8, 1, 0);
        check_val("t2_lock_final", bus.lock, 0);

        // 3: fb leads ref by 5 -> -5, dn 5 cycles, never locks
        ref_off = 5; fb_off = 0;
        do_reset();
        run(160, -5, 0, 5, 8, 1, 0);
        check_val("t3_lock_final", bus.lock, 0);

        // 4: locked at m=7, then m=8 -> period_ok drops, lock drops the cycle after
        lock_in_phase(7, 7);
        check_val("t4_locked", bus.lock, 1);
        bus.m = CNT_W'(8);
        wait_ev("t4_ev", 20);
        check_val("t4_period_ok", bus.period_ok, 0);
        check_val("t4_fb_period", bus.fb_period, 7);
        check_val("t4_lock_still", bus.lock, 1);
        tick();
        check_val("t4_lock_drop", bus.lock, 0);

        // 5: locked, then fb held low -> counters saturate at 1023, up stays high
        lock_in_phase(8, 8);
        check_val("t5_locked", bus.lock, 1);
        fb_en = 1'b0;
        hold_ev = 0;
        for (int i = 0; i < 1200; i++) begin
            tick();
            if (bus.err_valid) hold_ev++;
        end
        check_val("t5_no_ev", hold_ev, 0);
        check_val("t5_up_held", bus.up, 1);
        check_val("t5_lock_drop", bus.lock, 0);
        fb_en = 1'b1;
        wait_ev("t5_ev", 20);
        check_val("t5_phase_sat", $signed(bus.phase_err), 1023);
        check_val("t5_period_sat", bus.fb_period, 1023);
        check_val("t5_period_ok", bus.period_ok, 0);

        // 6: reset while in UP with lock=1; first fb edge afterwards only arms
        lock_in_phase(8, 8);
        fb_off = 3;
        begin
            int i;
            i = 0;
            do begin
                tick();
                i++;
            end while (!bus.up && i < 16);
        end
        check_val("t6_up_before", bus.up, 1);
        check_val("t6_lock_before", bus.lock, 1);
        rst = 1'b1;
        tick();
        rst = 1'b0;
        check_idle_outputs("t6_after_rst");
        wait_ev("t6_ev1", 40);
        check_val("t6_arm_period", bus.fb_period, 0);
        check_val("t6_arm_ok", bus.period_ok, 0);
        wait_ev("t6_ev2", 40);
        wait_ev("t6_ev3", 40);
        check_val("t6_period", bus.fb_period, 8);
        check_val("t6_period_ok", bus.period_ok, 1);

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_miss);
        $finish;
    end

endmodule
